stage_f: RTL and testbench

STAGE_F -- requirements
Module: stage_f

---
 rtl/stage_f_pkg.sv | 11 +
 rtl/stage_f_fifo.sv | 42 ++++
 rtl/stage_f.sv | 71 +++++++
 tb/tb_stage_f.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_f_pkg.sv
// stage_f_pkg: shared fetch-stage types, FSM state encodings and reset defaults
package stage_f_pkg;
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t FETCH = 1'b0;
  localparam fetch_state_t DRAIN = 1'b1;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/stage_f_fifo.sv
// fetch_fifo: DEPTH-entry circular prefetch buffer with push/pop/clear and occupancy count
module fetch_fifo
  import stage_f_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [2:0]   count
);
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_pop  = pop & (count != 3'd0);
  assign do_push = push & (count != 3'(DEPTH));
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/stage_f.sv
// stage_f: credit-based instruction fetch stage with prefetch buffer and redirect drain
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] TargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] RDD,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        InstrValidF
);
  fetch_state_t state;
  logic [31:0] nextpc;
  logic [2:0] outstanding, discard, count, inflight_n;
  logic grant, rsp, push, pop;
  fetch_entry_t head, rsp_entry;
  assign grant      = imem_req & imem_gnt;
  assign rsp        = imem_rvalid & (outstanding != 3'd0);
  assign imem_req   = rst & (state == FETCH) & ((count + outstanding) < 3'(DEPTH));
  assign imem_addr  = nextpc;
  assign push       = rsp & (state == FETCH) & ~RedirectE;
  assign pop        = InstrValidF & ~StallF & ~RedirectE;
  assign inflight_n = outstanding + 3'(grant) - 3'(rsp);
  // responses are in order, so the oldest in-flight request sits 4*outstanding behind nextpc
  assign rsp_entry  = '{pc: nextpc - (32'(outstanding) << 2), instr: imem_rdata};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= FETCH;
      nextpc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= inflight_n;
      if (RedirectE) begin
        nextpc  <= {TargetE[31:2], 2'b00};
        discard <= inflight_n;
        state   <= (inflight_n != 3'd0) ? DRAIN : FETCH;
      end else begin
        if (grant) nextpc <= nextpc + 32'd4;
        if (state == DRAIN) begin
          discard <= discard - 3'(rsp);
          if (discard == 3'(rsp)) state <= FETCH;
        end
      end
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(RedirectE),
    .push (push),
    .pop  (pop),
    .wdata(rsp_entry),
    .head (head),
    .count(count)
  );
  assign InstrValidF = (count != 3'd0);
  assign RDD         = InstrValidF ? head.instr : '0;
  assign PCF         = InstrValidF ? head.pc : '0;
  assign PCPlus4F    = InstrValidF ? head.pc + 32'd4 : '0;
endmodule

// File: tb/tb_stage_f.sv
// tb_stage_f: scoreboard bench for stage_f with zero-wait, held and random memory models
module tb_stage_f;
  logic clk = 0, rst = 0, StallF = 0, RedirectE = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] TargetE = 0, imem_rdata = 0;
  logic imem_req, InstrValidF, w_req, w_valid;
  logic [31:0] imem_addr, RDD, PCF, PCPlus4F, w_addr, w_rdd, w_pcf, w_pc4;
  logic [31:0] exp_q[$], pend[$];
  logic [31:0] req_pc = 32'h0, w_exp = 32'hFFFF_FFF8, w_req_pc = 32'hFFFF_FFF8;
  int checks = 0, errors = 0, mode = 0, w_pops = 0;
  bit wrap_on = 1;
  always #5 clk = ~clk;
  stage_f dut (
    .clk(clk), .rst(rst), .StallF(StallF), .RedirectE(RedirectE), .TargetE(TargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .RDD(RDD), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
  );
  stage_f #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .RedirectE(RedirectE), .TargetE(TargetE),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .RDD(w_rdd), .PCF(w_pcf), .PCPlus4F(w_pc4), .InstrValidF(w_valid)
  );
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  // one clock: drive memory at negedge, check/scoreboard at negedge+1, return at next negedge
  task automatic cycle();
    logic [31:0] e;
    imem_rvalid = pend.size() > 0 && (mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1));
    imem_rdata  = imem_rvalid ? instr_of(pend[0]) : 32'h0;
    imem_gnt    = (mode != 1) || ($urandom_range(0, 2) != 0);
    #1;
    if (InstrValidF && !StallF && !RedirectE) begin
      if (exp_q.size() == 0) check_eq("pop_without_request", 32'(InstrValidF), 32'h0);
      else begin
        e = exp_q.pop_front();
        check_eq("pcf", PCF, e);
        check_eq("rdd", RDD, instr_of(e));
        check_eq("pcplus4", PCPlus4F, e + 32'd4);
      end
    end
    if (wrap_on && w_valid && !StallF && !RedirectE) begin
      check_eq("wrap_pcf", w_pcf, w_exp);
      check_eq("wrap_pcplus4", w_pc4, w_exp + 32'd4);
      w_exp += 32'd4;
      w_pops++;
      if (w_pops == 3) wrap_on = 0;
    end
    if (wrap_on && w_req && imem_gnt) begin
      check_eq("wrap_addr", w_addr, w_req_pc);
      w_req_pc += 32'd4;
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (imem_req && imem_gnt) begin
      check_eq("req_addr", imem_addr, req_pc);
      exp_q.push_back(req_pc);
      pend.push_back(imem_addr);
      req_pc += 32'd4;
    end
    if (RedirectE) begin
      exp_q.delete();
      req_pc = TargetE;
    end
    @(negedge clk);
  endtask
  task automatic run_until_valid(input string tag);
    int n = 0;
    while (!InstrValidF && n < 40) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(InstrValidF), 32'h1);
  endtask
  task automatic run_until_drained(input string tag);
    int n = 0;
    while ((imem_req || InstrValidF) && n < 40) begin
      cycle();
      n++;
    end
    check_eq(tag, {imem_req, InstrValidF}, 32'h0);
  endtask
  task automatic async_reset(input string tag);
    #3 rst = 0;
    #1;
    check_eq({tag, "_req"}, 32'(imem_req), 32'h0);
    check_eq({tag, "_valid"}, 32'(InstrValidF), 32'h0);
    check_eq({tag, "_pcf"}, PCF, 32'h0);
    check_eq({tag, "_rdd"}, RDD, 32'h0);
    check_eq({tag, "_pcplus4"}, PCPlus4F, 32'h0);
    exp_q.delete();
    pend.delete();
    req_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    check_eq("reset_req", 32'(imem_req), 32'h0);
    check_eq("reset_valid", 32'(InstrValidF), 32'h0);
    check_eq("reset_pcf", PCF, 32'h0);
    check_eq("reset_rdd", RDD, 32'h0);
    check_eq("reset_pcplus4", PCPlus4F, 32'h0);
    check_eq("reset_wrap_valid", 32'(w_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    check_eq("startup_c0", 32'(InstrValidF), 32'h0);
    cycle();
    check_eq("startup_c1", 32'(InstrValidF), 32'h0);
    cycle();
    check_eq("startup_c2", 32'(InstrValidF), 32'h1);
    check_eq("startup_pcf", PCF, 32'h0);
    cycle();
    cycle();
    run_until_valid("stall_wait");
    check_eq("stall_head", PCF, 32'h8);
    StallF = 1;
    repeat (3) begin
      check_eq("stall_hold_pcf", PCF, 32'h8);
      check_eq("stall_req_low", 32'(imem_req), 32'h0);
      cycle();
    end
    StallF = 0;
    check_eq("full_first", 32'(InstrValidF), 32'h1);
    cycle();
    check_eq("full_second", 32'(InstrValidF), 32'h1);
    repeat (6) cycle();
    mode = 2;
    run_until_drained("fill_inflight");
    RedirectE = 1;
    TargetE = 32'h100;
    cycle();
    RedirectE = 0;
    check_eq("drain_req", 32'(imem_req), 32'h0);
    mode = 0;
    cycle();
    check_eq("drain_req2", 32'(imem_req), 32'h0);
    run_until_valid("redir_wait");
    check_eq("redir_pc", PCF, 32'h100);
    begin
      int n = 0;
      while (!(InstrValidF && pend.size() > 0) && n < 40) begin
        cycle();
        n++;
      end
    end
    RedirectE = 1;
    TargetE = 32'h200;
    cycle();
    RedirectE = 0;
    check_eq("flush_empty", 32'(InstrValidF), 32'h0);
    run_until_valid("redir2_wait");
    check_eq("redir2_pc", PCF, 32'h200);
    mode = 1;
    repeat (400) begin
      StallF = $urandom_range(0, 3) == 0;
      RedirectE = $urandom_range(0, 24) == 0;
      TargetE = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    StallF = 0;
    RedirectE = 0;
    mode = 0;
    StallF = 1;
    run_until_valid("hold_wait");
    async_reset("rst_valid");
    StallF = 0;
    run_until_valid("post_rst_wait");
    check_eq("post_rst_pc", PCF, 32'h0);
    repeat (4) cycle();
    mode = 2;
    run_until_drained("fill_inflight2");
    RedirectE = 1;
    TargetE = 32'h300;
    cycle();
    RedirectE = 0;
    check_eq("drain3_req", 32'(imem_req), 32'h0);
    async_reset("rst_drain");
    mode = 0;
    run_until_valid("post_drain_rst_wait");
    check_eq("post_drain_rst_pc", PCF, 32'h0);
    repeat (4) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
